// File: rtl/time_display_scan.sv
// Scans a six-digit HH:MM:SS seven-segment display from a once-per-frame snapshot of the
// time counters. The field selected for adjustment blinks at a frame-based rate.
module time_display_scan #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] blink_sel,
  output logic [5:0] digit_en,
  output logic [6:0] segments,
  output logic       dp,
  output logic       frame_start
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_DASH  = 7'b1000000;

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [4:0]    snap_hours;
  logic [5:0]    snap_minutes;
  logic [5:0]    snap_seconds;
  logic [1:0]    snap_blink;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          tick;

  assign tick = (pre == PRE_MAX);

  always_ff @(posedge clk) begin
    if (clear) begin
      pre          <= '0;
      idx          <= '0;
      snap_hours   <= '0;
      snap_minutes <= '0;
      snap_seconds <= '0;
      snap_blink   <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        pre <= '0;
        if (idx == 3'd5) begin
          // Frame boundary: take a coherent copy of the time so digits never tear.
          idx          <= '0;
          snap_hours   <= hours;
          snap_minutes <= minutes;
          snap_seconds <= seconds;
          snap_blink   <= blink_sel;
          frame_start  <= 1'b1;
          if (frame_cnt == FRAME_MAX) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd50)      return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] v, input logic [3:0] t);
    return 4'(v - 6'(t) * 6'd10);
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return SEG_DASH;
    endcase
  endfunction

  logic [5:0] hours_ext;
  logic [3:0] h_tens, h_units, m_tens, m_units, s_tens, s_units;
  logic       h_bad, m_bad, s_bad;

  assign hours_ext = {1'b0, snap_hours};
  assign h_tens    = tens_of(hours_ext);
  assign h_units   = units_of(hours_ext, h_tens);
  assign m_tens    = tens_of(snap_minutes);
  assign m_units   = units_of(snap_minutes, m_tens);
  assign s_tens    = tens_of(snap_seconds);
  assign s_units   = units_of(snap_seconds, s_tens);
  assign h_bad     = (snap_hours >= 5'd24);
  assign m_bad     = (snap_minutes >= 6'd60);
  assign s_bad     = (snap_seconds >= 6'd60);

  logic [3:0] digit;
  logic       bad;
  logic [1:0] field;
  logic [5:0] en_raw;
  logic [6:0] seg_raw;
  logic       dp_raw;

  always_comb begin
    digit = '0;
    bad   = 1'b0;
    field = 2'd0;
    unique case (idx)
      3'd0: begin digit = s_units; bad = s_bad; field = 2'd3; end
      3'd1: begin digit = s_tens;  bad = s_bad; field = 2'd3; end
      3'd2: begin digit = m_units; bad = m_bad; field = 2'd2; end
      3'd3: begin digit = m_tens;  bad = m_bad; field = 2'd2; end
      3'd4: begin digit = h_units; bad = h_bad; field = 2'd1; end
      3'd5: begin digit = h_tens;  bad = h_bad; field = 2'd1; end
      default: ;
    endcase

    seg_raw = bad ? SEG_DASH : seg_of(digit);
    en_raw  = 6'd1 << idx;
    if (blink_phase && (field != 2'd0) && (snap_blink == field)) begin
      en_raw = '0;
    end
    // Colon dots sit beside the minute and hour units; flash on even seconds.
    dp_raw = ((idx == 3'd2) || (idx == 3'd4)) && !snap_seconds[0];
  end

  assign digit_en = en_raw ^ {6{ACTIVE_LOW}};
  assign segments = seg_raw ^ {7{ACTIVE_LOW}};
  assign dp       = dp_raw ^ ACTIVE_LOW;

endmodule

// File: doc/time_display_scan.md
Name: time_display_scan

Overview:
Reader side of the time counters. Takes binary hours/minutes/seconds from the counter chain and drives a 6-digit multiplexed 7-segment display, HH:MM:SS. Time is snapshotted once per scan frame so the display never tears. The field selected for adjustment blinks.

Parameters:
SCAN_DIV, 1000, clk cycles each digit stays lit (>=2)
BLINK_FRAMES, 64, completed frames per blink half-period (>=1)
ACTIVE_LOW, 0, 1 = invert digit_en, segments, dp at the outputs

Ports:
clk  in  1  system clock
clear  in  1  synchronous reset, active-high
hours  in  5  binary hours, valid 0-23
minutes  in  6  binary minutes, valid 0-59
seconds  in  6  binary seconds, valid 0-59
blink_sel  in  2  field to blink: 0 none, 1 hours, 2 minutes, 3 seconds
digit_en  out  6  one-hot digit strobe; bit0 sec units, bit1 sec tens, bit2 min units, bit3 min tens, bit4 hr units, bit5 hr tens
segments  out  7  {g,f,e,d,c,b,a}
dp  out  1  colon dot
frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Prescaler pre counts 0..SCAN_DIV-1. tick = (pre==SCAN_DIV-1). pre wraps to 0 on tick.
- Digit index idx (0..5) increments on tick and wraps 5->0.
- Snapshot: on a tick with idx==5, latch hours, minutes, seconds and blink_sel into snapshot registers at the same edge idx wraps to 0.
- frame_start is registered. It is high for exactly the first cycle of each idx-0 slot reached by wrap. It is not asserted on the idx-0 slot after reset.
- Frame counter counts wraps 0..BLINK_FRAMES-1. On its wrap, blink_phase toggles.
- Outputs are combinational from internal registers only. There is no input-to-output path. A new digit appears at the edge where idx changes.
- Per-field BCD conversion of the snapshot: tens = 5/4/3/2/1/0 by compares (>=50, >=40 ...); units = v - 10*tens.
- The hours tens digit shows a leading 0.
- Out-of-range field (hours >= 24, minutes or seconds >= 60): both digits of that field show a dash, segments 1000000.
- Segment codes, {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- dp = 1 only when idx is 2 or 4 and snapshot seconds[0]==0 (colon flashes at 0.5 Hz).
- Blink: when blink_phase==1 and the snapshot blink_sel names the field of the current idx, digit_en = 000000 for that slot. segments still hold the code.
- Reset (clear high at a clk edge):
  - pre=0, idx=0, snapshots=0, frame counter=0, blink_phase=0, frame_start=0
  - resulting outputs: digit_en=000001, segments=0111111, dp=0
- clear has priority over tick, snapshot and every other update.
- Mid-frame reset aborts the frame. No frame_start is emitted for the post-reset slot.
- ACTIVE_LOW=1: bitwise invert digit_en, segments and dp after all of the above. Internal behaviour is unchanged.

Test Plan:
(SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=0)
1. Reset then release, inputs 0:0:0 -> digit_en 000001 for 4 cycles, then 000010, ... 100000, back to 000001 with frame_start high 1 cycle; segments 0111111 throughout; dp 1 during idx 2 and 4.
2. Inputs 23:59:58 held 2 frames -> second frame segments per idx 0..5 are 1111111, 1101101, 1101111, 1101101, 1001111, 1011011; dp 1 at idx 2 and 4.
3. Change inputs from 12:34:56 to 01:02:03 while idx=2 -> remaining slots of that frame still show 12:34:56; next frame shows 01:02:03.
4. minutes=60, hours=24 -> idx 2-5 segments 1000000; seconds digits still correct.
5. blink_sel=2, 8 frames -> digit_en 0 during idx 2 and 3 in frames with blink_phase 1 (frames 3-4 and 7-8), normal otherwise; other digits are never blanked.
6. clear pulsed 1 cycle at idx=4, pre=2 -> next cycle digit_en 000001, segments 0111111, pre restarts; first frame_start appears only after the next idx 5->0 wrap.
